softmax_row_sequencer: RTL and testbench

// - Initiator for the integer-softmax engine: drives its q_in_soft / EN_max / EN_acc

---
 rtl/softmax_row_sequencer_pkg.sv | 6 +
 rtl/softmax_row_sequencer_if.sv | 26 ++
 rtl/softmax_row_sequencer_buf.sv | 18 +
 rtl/softmax_row_sequencer.sv | 78 +++++++
 tb/tb_softmax_row_sequencer.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/softmax_row_sequencer_pkg.sv
// softmax_row_sequencer_pkg: shared widths and state type for the softmax row sequencer
package softmax_row_sequencer_pkg;
  localparam int DATA_W = 32;
  localparam int ST_W = 2;
  typedef enum logic [ST_W-1:0] {IDLE, LOAD, ACC, OUT} state_t;
endpackage

// File: rtl/softmax_row_sequencer_if.sv
// softmax_row_sequencer_if: score stream in, result stream out, and softmax engine pins
interface softmax_row_sequencer_if #(
  parameter int DATA_W = softmax_row_sequencer_pkg::DATA_W
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic [DATA_W-1:0] q_in_soft;
  logic              en_max;
  logic              en_acc;
  logic              eng_rst_n;
  logic [DATA_W-1:0] q_out_soft;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  modport master (
    input  in_valid, in_data, in_last, q_out_soft, out_ready,
    output in_ready, q_in_soft, en_max, en_acc, eng_rst_n, out_valid, out_data, out_last
  );
  modport slave (
    output in_valid, in_data, in_last, q_out_soft, out_ready,
    input  in_ready, q_in_soft, en_max, en_acc, eng_rst_n, out_valid, out_data, out_last
  );
endinterface

// File: rtl/softmax_row_sequencer_buf.sv
// softmax_row_buf: one row of scores, single write port and combinational read port
module softmax_row_buf #(
  parameter int DATA_W  = softmax_row_sequencer_pkg::DATA_W,
  parameter int ROW_LEN = 16,
  localparam int AW     = $clog2(ROW_LEN)
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [ROW_LEN];
  always_ff @(posedge CLK)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/softmax_row_sequencer.sv
// softmax_row_sequencer: buffers a score row and replays it to the softmax engine in max, accumulate and output passes
module softmax_row_sequencer
  import softmax_row_sequencer_pkg::*;
#(
  parameter int DATA_W  = softmax_row_sequencer_pkg::DATA_W,
  parameter int ROW_LEN = 16,
  parameter int CNT_W   = $clog2(ROW_LEN) + 1
) (
  input  logic                    CLK,
  input  logic                    RST_n,
  softmax_row_sequencer_if.master bus,
  output logic                    busy,
  output logic                    err_ovf
);
  localparam int AW = $clog2(ROW_LEN);
  state_t            state;
  logic [CNT_W-1:0]  len;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en, at_end, wr_full;
  assign wr_en   = state == LOAD && bus.in_valid;
  assign wr_full = wr_ptr == AW'(ROW_LEN - 1);
  assign at_end  = CNT_W'(rd_ptr) == len - CNT_W'(1);
  assign busy    = state != IDLE;
  softmax_row_buf #(.DATA_W(DATA_W), .ROW_LEN(ROW_LEN)) u_buf (
    .CLK  (CLK),
    .we   (wr_en),
    .waddr(wr_ptr),
    .wdata(bus.in_data),
    .raddr(rd_ptr),
    .rdata(rd_data)
  );
  always_ff @(posedge CLK)
    if (!RST_n) begin
      state   <= IDLE;
      len     <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      err_ovf <= 1'b0;
    end else
      case (state)
        IDLE: begin
          state  <= LOAD;
          len    <= '0;
          wr_ptr <= '0;
          rd_ptr <= '0;
        end
        LOAD: if (bus.in_valid) begin
          wr_ptr <= wr_ptr + 1'b1;
          len    <= len + 1'b1;
          if (bus.in_last || wr_full) begin
            state  <= ACC;
            rd_ptr <= '0;
          end
          if (!bus.in_last && wr_full) err_ovf <= 1'b1;
        end
        ACC: begin
          rd_ptr <= at_end ? '0 : rd_ptr + 1'b1;
          if (at_end) state <= OUT;
        end
        OUT: if (bus.out_ready) begin
          rd_ptr <= rd_ptr + 1'b1;
          if (at_end) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
  // engine pins follow the state directly so max tracking sees each beat as it is accepted
  always_comb begin
    bus.in_ready  = state == LOAD;
    bus.en_max    = state == LOAD && bus.in_valid;
    bus.en_acc    = state == ACC;
    bus.eng_rst_n = state != IDLE;
    bus.q_in_soft = state == LOAD ? bus.in_data : state == IDLE ? '0 : rd_data;
    bus.out_valid = state == OUT;
    bus.out_data  = bus.q_out_soft;
    bus.out_last  = state == OUT && at_end;
  end
endmodule

// File: tb/tb_softmax_row_sequencer.sv
// tb_softmax_row_sequencer: directed rows through the sequencer with a small engine model
module tb_softmax_row_sequencer;
  logic CLK = 1'b0;
  logic RST_n;
  logic busy, err_ovf;
  int checks = 0;
  int errors = 0;
  logic [31:0] row [16];
  logic [31:0] exp_o [16];
  logic signed [31:0] e_max, e_acc;

  softmax_row_sequencer_if bus ();

  softmax_row_sequencer dut (
    .CLK    (CLK),
    .RST_n  (RST_n),
    .bus    (bus),
    .busy   (busy),
    .err_ovf(err_ovf)
  );

  always #5 CLK = ~CLK;

  // engine model: result = element + sum - max
  always_ff @(posedge CLK)
    if (!bus.eng_rst_n) begin
      e_max <= 32'sh8000_0000;
      e_acc <= '0;
    end else begin
      if (bus.en_max && $signed(bus.q_in_soft) > e_max) e_max <= bus.q_in_soft;
      if (bus.en_acc) e_acc <= e_acc + bus.q_in_soft;
    end
  assign bus.q_out_soft = bus.q_in_soft + e_acc - e_max;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic beat(input logic [31:0] d, input bit last, input bit gap);
    int k;
    k = 0;
    if (gap) begin
      @(posedge CLK); #1;
      bus.in_valid = 1'b0;
      #1;
      chk("gap_en_max", bus.en_max, 0);
    end
    @(posedge CLK); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    #1;
    while (!bus.in_ready && k < 20) begin
      @(posedge CLK); #2;
      k++;
    end
    chk("load_in_ready", bus.in_ready, 1);
    chk("load_en_max", bus.en_max, 1);
    chk("load_q", bus.q_in_soft, d);
  endtask

  task automatic acc_phase(input int n, input bit stray);
    @(posedge CLK); #1;
    bus.in_valid = stray;
    bus.in_data  = 32'd100;
    bus.in_last  = 1'b1;
    #1;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        @(posedge CLK); #2;
      end
      chk("acc_en_acc", bus.en_acc, 1);
      chk("acc_q", bus.q_in_soft, row[i]);
      chk("acc_en_max", bus.en_max, 0);
      chk("acc_in_ready", bus.in_ready, 0);
    end
  endtask

  task automatic out_phase(input int n, input logic [3:0] pat);
    int idx, c;
    idx = 0;
    c = 0;
    while (idx < n && c < 4 * n + 8) begin
      @(posedge CLK); #1;
      bus.out_ready = pat[c % 4];
      #1;
      chk("out_valid", bus.out_valid, 1);
      chk("out_en_acc", bus.en_acc, 0);
      chk("out_q", bus.q_in_soft, row[idx]);
      chk("out_data", bus.out_data, exp_o[idx]);
      chk("out_last", bus.out_last, 32'(idx == n - 1));
      if (bus.out_ready) idx++;
      c++;
    end
    chk("out_count", idx, n);
  endtask

  task automatic idle_phase();
    @(posedge CLK); #2;
    chk("idle_eng_rst_n", bus.eng_rst_n, 0);
    chk("idle_busy", busy, 0);
    chk("idle_out_valid", bus.out_valid, 0);
    chk("idle_in_ready", bus.in_ready, 0);
    chk("idle_en_max", bus.en_max, 0);
  endtask

  task automatic run_row(input int n, input bit use_last, input bit gap, input bit stray, input logic [3:0] pat);
    for (int i = 0; i < n; i++) beat(row[i], use_last && i == n - 1, gap);
    acc_phase(n, stray);
    out_phase(n, pat);
    idle_phase();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_en_max", bus.en_max, 0);
    chk("rst_en_acc", bus.en_acc, 0);
    chk("rst_q", bus.q_in_soft, 0);
    chk("rst_err_ovf", err_ovf, 0);
    chk("rst_busy", busy, 0);
    chk("rst_eng_rst_n", bus.eng_rst_n, 0);
    RST_n = 1'b1;

    row[0] = 5; row[1] = -3; row[2] = 7; row[3] = 7;
    exp_o[0] = 14; exp_o[1] = 6; exp_o[2] = 16; exp_o[3] = 16;
    run_row(4, 1, 0, 0, 4'b1111);
    chk("t1_err_ovf", err_ovf, 0);

    row[0] = 9; exp_o[0] = 9;
    run_row(1, 1, 0, 0, 4'b1111);
    @(posedge CLK); #2;
    chk("t2_load_eng_rst_n", bus.eng_rst_n, 1);
    chk("t2_load_in_ready", bus.in_ready, 1);

    for (int i = 0; i < 16; i++) begin
      row[i] = i - 4;
      exp_o[i] = i + 41;
    end
    run_row(16, 0, 0, 1, 4'b1111);
    chk("t3_err_ovf", err_ovf, 1);
    row[0] = 100; exp_o[0] = 100;
    run_row(1, 1, 0, 0, 4'b1111);
    chk("t3_err_sticky", err_ovf, 1);

    row[0] = 1; row[1] = 2; row[2] = 3;
    exp_o[0] = 4; exp_o[1] = 5; exp_o[2] = 6;
    run_row(3, 1, 0, 0, 4'b1001);

    row[0] = -1; row[1] = 6; row[2] = 2;
    exp_o[0] = 0; exp_o[1] = 7; exp_o[2] = 3;
    run_row(3, 1, 1, 0, 4'b1111);

    bus.out_ready = 1'b1;
    beat(32'd4, 0, 0);
    beat(32'd4, 1, 0);
    @(posedge CLK); #1;
    bus.in_valid = 1'b0;
    #1;
    chk("t5_in_acc", bus.en_acc, 1);
    @(posedge CLK); #1;
    RST_n = 1'b0;
    @(posedge CLK); #1;
    chk("t5_out_valid", bus.out_valid, 0);
    chk("t5_en_acc", bus.en_acc, 0);
    chk("t5_busy", busy, 0);
    chk("t5_err_ovf", err_ovf, 0);
    RST_n = 1'b1;
    row[0] = 2; row[1] = -8;
    exp_o[0] = -6; exp_o[1] = -16;
    run_row(2, 1, 0, 0, 4'b1111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
